// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue_if: bundles the producer write port, queue status and the
// launch handshake towards uart_top.
//   master : producer/UART side (drives wr_en, wr_data, uart_tx_busy)
//   slave  : the queue (drives status, drop_cnt, uart_trig, uart_tx_data)
interface uart_tx_queue_if #(
  parameter int unsigned DEPTH_LOG2 = 4
);
  logic                  wr_en;
  logic [7:0]            wr_data;
  logic                  full;
  logic                  empty;
  logic [DEPTH_LOG2:0]   level;
  logic [7:0]            drop_cnt;
  logic                  uart_trig;
  logic [7:0]            uart_tx_data;
  logic                  uart_tx_busy;

  modport master (
    output wr_en, wr_data, uart_tx_busy,
    input  full, empty, level, drop_cnt, uart_trig, uart_tx_data
  );

  modport slave (
    input  wr_en, wr_data, uart_tx_busy,
    output full, empty, level, drop_cnt, uart_trig, uart_tx_data
  );
endinterface

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: circular byte queue that launches bytes one at a time into
// the UART transmitter and tracks its busy flag, so bursty producers never
// lose bytes to a busy transmitter.
//
// Ports:
//   clk            system clock
//   rstn           synchronous active-low reset
//   bus (slave)    wr_en/wr_data  : enqueue one byte per asserted cycle
//                  full/empty/level : registered occupancy status
//                  drop_cnt       : rejected-write counter (saturating)
//                  uart_trig      : one-cycle launch pulse
//                  uart_tx_data   : launched byte, held until next launch
//                  uart_tx_busy   : transmitter busy from uart_top
//
// Build option: define UART_TXQ_DROP_CNT_EN to build the rejected-write
// counter; otherwise drop_cnt reads 8'h00 and drops are silent.
module uart_tx_queue #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned BUSY_WAIT  = 4
) (
  input  logic          clk,
  input  logic          rstn,
  uart_tx_queue_if.slave bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(BUSY_WAIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [DEPTH_LOG2-1:0]  wp_q, wp_d;
  logic [DEPTH_LOG2-1:0]  rp_q, rp_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   trig_q, trig_d;
  logic [7:0]             data_q, data_d;
  logic                   full_q, full_d;
  logic                   empty_q, empty_d;
  logic                   pop;
  logic                   wr_ok;

  // Storage; intentionally not reset.
  logic [7:0]             mem_q [DEPTH];

  // Next-state, pointer and status computation.
  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    data_d  = data_q;

    // Pop decision uses the pre-edge level, so a byte written this cycle
    // can never be the one popped.
    pop   = (state_q == ST_IDLE) && (level_q != '0) && !bus.uart_tx_busy;
    // A pop frees a slot in the same cycle, so a full queue still accepts.
    wr_ok = bus.wr_en && ((level_q != LVL_FULL) || pop);

    case (state_q)
      ST_IDLE: begin
        if (pop) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (bus.uart_tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == WAIT_LAST) begin
          // Transmitter never acknowledged; treat the byte as sent.
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.uart_tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      data_d = mem_q[rp_q];
      rp_d   = rp_q + 1'b1;
    end

    if (wr_ok) wp_d = wp_q + 1'b1;

    case ({wr_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // Registered outputs track the next state / next level exactly.
    trig_d  = (state_d == ST_LAUNCH);
    full_d  = (level_d == LVL_FULL);
    empty_d = (level_d == '0);
  end

`ifdef UART_TXQ_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;

  // Saturating count of rejected writes.
  always_comb begin
    drop_d = drop_q;
    if (bus.wr_en && !wr_ok && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end
`endif

  // State register for the FSM, pointers, level and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      trig_q  <= 1'b0;
      data_q  <= 8'h00;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
`ifdef UART_TXQ_DROP_CNT_EN
      drop_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      trig_q  <= trig_d;
      data_q  <= data_d;
      full_q  <= full_d;
      empty_q <= empty_d;
`ifdef UART_TXQ_DROP_CNT_EN
      drop_q  <= drop_d;
`endif
    end
  end

  // Byte storage write port.
  always_ff @(posedge clk) begin
    if (rstn && wr_ok) mem_q[wp_q] <= bus.wr_data;
  end

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.level        = level_q;
  assign bus.uart_trig    = trig_q;
  assign bus.uart_tx_data = data_q;
`ifdef UART_TXQ_DROP_CNT_EN
  assign bus.drop_cnt     = drop_q;
`else
  assign bus.drop_cnt     = 8'h00;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed self-checking bench for uart_tx_queue with a
// simple transmitter busy model and a receive scoreboard.
module tb_uart_tx_queue;

  localparam int unsigned DL2 = 4;
  localparam int unsigned BW  = 4;

`ifdef UART_TXQ_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  uart_tx_queue_if #(.DEPTH_LOG2(DL2)) bus();

  uart_tx_queue #(.DEPTH_LOG2(DL2), .BUSY_WAIT(BW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Busy source: either the automatic model or a manually driven level.
  logic auto_busy = 1'b0;
  logic busy_man  = 1'b0;
  logic busy_mdl  = 1'b0;
  int   hold      = 0;
  int   busy_cnt  = 0;
  assign bus.uart_tx_busy = auto_busy ? busy_mdl : busy_man;

  int          cyc = 0;
  logic [7:0]  rx_q[$];
  int          trig_t[$];

  // Scoreboard capture and busy model: busy rises the cycle after a
  // trigger and stays high for 'hold' cycles (never rises if hold==0).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.uart_trig) begin
      rx_q.push_back(bus.uart_tx_data);
      trig_t.push_back(cyc);
    end
    if (!auto_busy) begin
      busy_mdl <= 1'b0;
      busy_cnt <= 0;
    end else if (busy_cnt == 0) begin
      if (bus.uart_trig && hold != 0) begin
        busy_mdl <= 1'b1;
        busy_cnt <= hold;
      end
    end else if (busy_cnt == 1) begin
      busy_mdl <= 1'b0;
      busy_cnt <= 0;
    end else begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq("rx_count", 32'(rx_q.size()), 32'(n));
  endtask

  // Global bound so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int tbase;
    logic [7:0] e;

    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;

    // Reset values (sampled while reset still asserted).
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_empty", 32'(bus.empty), 32'd1);
    check_eq("rst_full", 32'(bus.full), 32'd0);
    check_eq("rst_level", 32'(bus.level), 32'd0);
    check_eq("rst_trig", 32'(bus.uart_trig), 32'd0);
    check_eq("rst_data", 32'(bus.uart_tx_data), 32'h00);
    check_eq("rst_drop", 32'(bus.drop_cnt), 32'd0);
    rstn = 1'b1;

    // Single byte: trig exactly one cycle after the write edge.
    auto_busy = 1'b1;
    hold = 3;
    base = rx_q.size();
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hA5;
    @(negedge clk);
    bus.wr_en = 1'b0;
    check_eq("one_trig_k0", 32'(bus.uart_trig), 32'd0);
    check_eq("one_level_k0", 32'(bus.level), 32'd1);
    @(negedge clk);
    check_eq("one_trig_k1", 32'(bus.uart_trig), 32'd1);
    check_eq("one_data_k1", 32'(bus.uart_tx_data), 32'hA5);
    @(negedge clk);
    check_eq("one_trig_k2", 32'(bus.uart_trig), 32'd0);
    repeat (10) @(negedge clk);
    check_eq("one_level_end", 32'(bus.level), 32'd0);
    check_eq("one_empty_end", 32'(bus.empty), 32'd1);
    check_eq("one_data_held", 32'(bus.uart_tx_data), 32'hA5);
    check_eq("one_rx_cnt", 32'(rx_q.size() - base), 32'd1);

    // Burst of 20 into a slow transmitter: 1 popped, 16 held, 3 dropped.
    do_reset();
    auto_busy = 1'b1;
    hold = 100;
    base = rx_q.size();
    for (int i = 0; i < 20; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(i);
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    check_eq("burst_full", 32'(bus.full), 32'd1);
    check_eq("burst_level", 32'(bus.level), 32'd16);
    check_eq("burst_drop", 32'(bus.drop_cnt), DROP_EN ? 32'd3 : 32'd0);
    wait_rx(base + 17, 4000);
    repeat (120) @(negedge clk);
    check_eq("burst_rx_total", 32'(rx_q.size() - base), 32'd17);
    for (int i = 0; i < 17 && base + i < rx_q.size(); i++)
      check_eq($sformatf("burst_rx%0d", i), 32'(rx_q[base + i]), 32'(i));
    check_eq("burst_empty", 32'(bus.empty), 32'd1);

    // Full queue, busy held high: no launch; then write+pop together.
    do_reset();
    auto_busy = 1'b0;
    busy_man = 1'b1;
    base = rx_q.size();
    for (int i = 0; i < 16; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(8'h50 + i);
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    check_eq("sim_level16", 32'(bus.level), 32'd16);
    check_eq("sim_full", 32'(bus.full), 32'd1);
    check_eq("sim_no_launch_busy", 32'(rx_q.size() - base), 32'd0);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h60;
    @(negedge clk);
    bus.wr_en = 1'b0;
    check_eq("sim_reject_level", 32'(bus.level), 32'd16);
    check_eq("sim_reject_drop", 32'(bus.drop_cnt), DROP_EN ? 32'd1 : 32'd0);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h61;
    busy_man = 1'b0;
    @(negedge clk);
    bus.wr_en = 1'b0;
    busy_man = 1'b1;
    check_eq("sim_trig", 32'(bus.uart_trig), 32'd1);
    check_eq("sim_data", 32'(bus.uart_tx_data), 32'h50);
    check_eq("sim_level_kept", 32'(bus.level), 32'd16);
    check_eq("sim_full_kept", 32'(bus.full), 32'd1);
    check_eq("sim_drop_kept", 32'(bus.drop_cnt), DROP_EN ? 32'd1 : 32'd0);
    auto_busy = 1'b1;
    hold = 2;
    wait_rx(base + 17, 800);
    for (int i = 0; i < 17 && base + i < rx_q.size(); i++) begin
      e = (i < 16) ? 8'(8'h50 + i) : 8'h61;
      check_eq($sformatf("sim_rx%0d", i), 32'(rx_q[base + i]), 32'(e));
    end

    // Pointer wrap: 40 bytes, one every 8 cycles, slower transmitter.
    do_reset();
    auto_busy = 1'b1;
    hold = 8;
    base = rx_q.size();
    for (int i = 0; i < 40; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(8'h20 + i);
      @(negedge clk);
      bus.wr_en = 1'b0;
      repeat (7) @(negedge clk);
    end
    wait_rx(base + 40, 2000);
    repeat (30) @(negedge clk);
    check_eq("wrap_rx_total", 32'(rx_q.size() - base), 32'd40);
    for (int i = 0; i < 40 && base + i < rx_q.size(); i++)
      check_eq($sformatf("wrap_rx%0d", i), 32'(rx_q[base + i]), 32'(8'h20 + i));
    check_eq("wrap_drop", 32'(bus.drop_cnt), 32'd0);
    check_eq("wrap_empty", 32'(bus.empty), 32'd1);

    // Busy never rises: launches spaced BUSY_WAIT+2 cycles.
    do_reset();
    auto_busy = 1'b1;
    hold = 0;
    base = rx_q.size();
    tbase = trig_t.size();
    for (int i = 0; i < 3; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(8'hC0 + i);
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    wait_rx(base + 3, 100);
    if (trig_t.size() >= tbase + 3) begin
      check_eq("nobusy_gap1", 32'(trig_t[tbase + 1] - trig_t[tbase]), 32'(BW + 2));
      check_eq("nobusy_gap2", 32'(trig_t[tbase + 2] - trig_t[tbase + 1]), 32'(BW + 2));
      for (int i = 0; i < 3; i++)
        check_eq($sformatf("nobusy_rx%0d", i), 32'(rx_q[base + i]), 32'(8'hC0 + i));
    end

    // Reset during WAIT_DONE with 5 bytes queued flushes everything.
    do_reset();
    auto_busy = 1'b0;
    busy_man = 1'b0;
    base = rx_q.size();
    for (int i = 0; i < 6; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(8'h70 + i);
      @(negedge clk);
      if (i == 1) busy_man = 1'b1;
    end
    bus.wr_en = 1'b0;
    check_eq("mid_level5", 32'(bus.level), 32'd5);
    check_eq("mid_one_launch", 32'(rx_q.size() - base), 32'd1);
    rstn = 1'b0;
    busy_man = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_level", 32'(bus.level), 32'd0);
    check_eq("mid_rst_empty", 32'(bus.empty), 32'd1);
    check_eq("mid_rst_full", 32'(bus.full), 32'd0);
    check_eq("mid_rst_trig", 32'(bus.uart_trig), 32'd0);
    check_eq("mid_rst_data", 32'(bus.uart_tx_data), 32'h00);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("mid_no_more_launch", 32'(rx_q.size() - base), 32'd1);
    check_eq("mid_level_after", 32'(bus.level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Byte queue feeding the transmit side of `uart_top`. Upstream logic writes bytes at any rate up to one per clock. The queue holds them in a circular buffer and launches them one at a time into the UART transmitter, driving its `uart_trig`/`uart_tx_data` and tracking `uart_tx_busy`. This replaces ad-hoc gating of the form `trig & ~busy` and removes byte loss when the producer bursts.

## Interface
- `DEPTH_LOG2`, 4: log2 of queue depth; depth = 2^DEPTH_LOG2 entries of 8 bits.
- `BUSY_WAIT`, 4: cycles to wait after a launch for `uart_tx_busy` to rise before giving up; range 1..15.

- `clk`  in  1  system clock; the only clock.
- `rstn`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  write strobe; one byte per asserted cycle.
- `wr_data`  in  8  byte to enqueue.
- `full`  out  1  level == depth.
- `empty`  out  1  level == 0.
- `level`  out  DEPTH_LOG2+1  number of bytes currently held.
- `drop_cnt`  out  8  count of rejected writes (see Configuration).
- `uart_trig`  out  1  one-cycle launch pulse to `uart_top`.
- `uart_tx_data`  out  8  byte being launched; held stable until the next launch.
- `uart_tx_busy`  in  1  transmitter busy, from `uart_top`.

## Operation
- Storage: 2^DEPTH_LOG2 x 8 array. Write pointer `wp` and read pointer `rp` are DEPTH_LOG2 bits wide and wrap modulo depth. `level` is a separate counter.
- Write acceptance: a write is accepted when `wr_en=1` and either level < depth, or a pop occurs in the same cycle.
  - An accepted write stores `mem[wp] <= wr_data` and increments `wp`.
  - A rejected write changes no storage.
- Pop: occurs on the IDLE->LAUNCH transition.
  - `uart_tx_data <= mem[rp]` and `rp++`.
  - A pop of the entry written in the same cycle is impossible: the pop uses the level before the edge.
- Level update: `level` += accepted write, -= pop. A simultaneous write and pop leaves `level` unchanged.
- FSM (registered state):
  - IDLE: if level != 0 and `uart_tx_busy`=0, pop and go to LAUNCH. Otherwise stay.
  - LAUNCH: `uart_trig`=1 for exactly this cycle. Clear the wait counter and go to WAIT_BUSY.
  - WAIT_BUSY: if `uart_tx_busy`=1, go to WAIT_DONE. Otherwise, if wait counter == BUSY_WAIT-1, go to IDLE (byte is treated as sent). Otherwise increment the counter.
  - WAIT_DONE: if `uart_tx_busy`=0, go to IDLE.
- `uart_trig` is high only in LAUNCH. It is never asserted while `uart_tx_busy`=1 was sampled at the launching edge.
- `full`/`empty` are decoded from the registered `level`.

## Timing
- Reset values (on any edge with `rstn`=0):
  - state=IDLE, `wp`=`rp`=0, `level`=0.
  - `uart_trig`=0, `uart_tx_data`=8'h00, `drop_cnt`=0, `empty`=1, `full`=0.
  - Reset mid-transfer flushes the queue without finishing any sequence. The memory contents are not reset.
- Latency: a write sampled at edge k into an empty queue, in IDLE with busy low, gives `uart_trig` high during cycle k+1..k+2, with `uart_tx_data` valid in that same cycle.
- Minimum spacing between launches is 4 cycles (LAUNCH, WAIT_BUSY, WAIT_DONE, IDLE), more while busy is held.
- Wrap-around: `wp`/`rp` roll from depth-1 to 0 with no gap. The `level` counter distinguishes full from empty.
- Busy already high while in IDLE: no launch until busy is sampled low.

## Configuration
- `UART_TXQ_DROP_CNT_EN` defined:
  - `drop_cnt` increments on every rejected write.
  - It saturates at 8'hFF and is cleared only by reset.
- `UART_TXQ_DROP_CNT_EN` undefined:
  - `drop_cnt` is tied to 8'h00 and no counter logic is built.
  - Rejected writes are dropped silently.

## Test plan
- Single byte: reset, write 8'hA5 with busy model idle → `uart_trig` pulses once, 2 cycles after the write, with `uart_tx_data`=8'hA5; `level` returns to 0.
- Burst to full (DEPTH_LOG2=4): write 8'h00..8'h13 on 20 consecutive cycles, busy model holding busy 100 cycles per byte.
  - `full`=1 after the queue fills.
  - `drop_cnt`=3 with the macro defined, 0 without.
  - UART receives 8'h00..8'h10 in order (17 bytes: one popped during the burst, 16 held).
- Simultaneous write and pop while full → write accepted, `level` stays 16, no drop counted.
- Pointer wrap: 40 bytes 8'h20..8'h47 at one write per 8 cycles → all received in order, no duplicates.
- Busy never rises: tie `uart_tx_busy`=0, write 3 bytes → 3 trig pulses spaced BUSY_WAIT+2 cycles apart.
- Reset mid-op: assert `rstn`=0 for one edge during WAIT_DONE with level=5 → next cycle state=IDLE, `level`=0, `empty`=1, `uart_trig`=0, no further launches.
